// File: rtl/lsu_ctrl_pkg.sv
// Shared constants for the load/store unit: RV32I funct3 width codes,
// exception codes and the controller state type.
package lsu_ctrl_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [1:0] EXC_MISALIGNED = 2'd0;
    localparam logic [1:0] EXC_ILLEGAL    = 2'd1;
    localparam logic [1:0] EXC_RANGE      = 2'd2;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// Picks the addressed byte or half out of a memory word and sign- or
// zero-extends it according to the load's funct3.
module load_align
    import lsu_ctrl_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[8*offset_i +: 8];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        unique case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, combinational store lanes,
// one-cycle-latency loads with registered write-back and registered faults.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    input  logic        flush_i,
    output logic [31:0] w_addr_o,
    output logic [31:0] r_addr_o,
    output logic [31:0] w_data_o,
    output logic [3:0]  w_en_o,
    output logic        r_en_o,
    input  logic [31:0] r_data_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        exc_valid_o,
    output logic        exc_store_o,
    output logic [1:0]  exc_code_o,
    output logic [31:0] exc_addr_o
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_valid_q, exc_valid_d;
    logic        exc_store_q, exc_store_d;
    logic [1:0]  exc_code_q, exc_code_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;
    logic [1:0]  fault_code;
    logic [3:0]  lane_mask;
    logic [31:0] word_idx;
    logic [31:0] align_data;

    load_align u_load_align (
        .offset_i (off_q),
        .funct3_i (f3_q),
        .rdata_i  (r_data_i),
        .data_o   (align_data)
    );

    // Request decode and memory-side strobes, all in the accepting cycle.
    always_comb begin
        req_ready_o = (state_q == ST_IDLE) & ~flush_i;
        accept      = req_valid_i & req_ready_o;

        if (req_we_i) begin
            illegal = (req_funct3_i >= 3'd3);
        end else begin
            illegal = (req_funct3_i == 3'd3) | (req_funct3_i == 3'd6) | (req_funct3_i == 3'd7);
        end
        misaligned   = ((req_funct3_i[1:0] == 2'd1) & req_addr_i[0])
                     | ((req_funct3_i[1:0] == 2'd2) & (req_addr_i[1:0] != 2'd0));
        out_of_range = ((req_addr_i >> (MEM_AW + 2)) != 32'd0);
        fault        = illegal | misaligned | out_of_range;

        if (illegal) begin
            fault_code = EXC_ILLEGAL;
        end else if (misaligned) begin
            fault_code = EXC_MISALIGNED;
        end else begin
            fault_code = EXC_RANGE;
        end

        word_idx = {{(32 - MEM_AW){1'b0}}, req_addr_i[MEM_AW+1:2]};
        w_addr_o = word_idx;
        r_addr_o = word_idx;

        unique case (req_funct3_i[1:0])
            2'd0: begin
                lane_mask = 4'b0001 << req_addr_i[1:0];
                w_data_o  = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                lane_mask = req_addr_i[1] ? 4'b1100 : 4'b0011;
                w_data_o  = {2{req_wdata_i[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                w_data_o  = req_wdata_i;
            end
        endcase

        w_en_o = (accept & req_we_i & ~fault) ? lane_mask : 4'b0000;
        r_en_o = accept & ~req_we_i & ~fault;
    end

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        f3_d        = f3_q;
        rd_d        = rd_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_store_d = exc_store_q;
        exc_code_d  = exc_code_q;
        exc_addr_d  = exc_addr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept && fault) begin
                    exc_valid_d = 1'b1;
                    exc_store_d = req_we_i;
                    exc_code_d  = fault_code;
                    exc_addr_d  = req_addr_i;
                end else if (accept && !req_we_i) begin
                    off_d   = req_addr_i[1:0];
                    f3_d    = req_funct3_i;
                    rd_d    = req_rd_i;
                    state_d = ST_LOAD_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                // A flush here simply drops the returning read data.
                state_d = ST_IDLE;
                if (!flush_i) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = align_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            off_q       <= 2'd0;
            f3_q        <= 3'd0;
            rd_q        <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            exc_valid_q <= 1'b0;
            exc_store_q <= 1'b0;
            exc_code_q  <= 2'd0;
            exc_addr_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            rd_q        <= rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_store_q <= exc_store_d;
            exc_code_q  <= exc_code_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign exc_valid_o = exc_valid_q;
    assign exc_store_o = exc_store_q;
    assign exc_code_o  = exc_code_q;
    assign exc_addr_o  = exc_addr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed plus randomized bench for lsu_ctrl against a byte-addressed
// reference memory and request-level fault/extension rules.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int MEM_AW = 12;
    localparam int WORDS  = 1 << MEM_AW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [2:0]  req_funct3_i = 3'd0;
    logic [31:0] req_addr_i = 32'd0;
    logic [31:0] req_wdata_i = 32'd0;
    logic [4:0]  req_rd_i = 5'd0;
    logic        flush_i = 1'b0;
    logic [31:0] w_addr_o;
    logic [31:0] r_addr_o;
    logic [31:0] w_data_o;
    logic [3:0]  w_en_o;
    logic        r_en_o;
    logic [31:0] r_data_i = 32'd0;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        exc_valid_o;
    logic        exc_store_o;
    logic [1:0]  exc_code_o;
    logic [31:0] exc_addr_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [WORDS] = '{default: 32'd0};
    logic [7:0]  ref_mem [WORDS*4] = '{default: 8'd0};

    lsu_ctrl #(.MEM_AW(MEM_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_rd_i     (req_rd_i),
        .flush_i      (flush_i),
        .w_addr_o     (w_addr_o),
        .r_addr_o     (r_addr_o),
        .w_data_o     (w_data_o),
        .w_en_o       (w_en_o),
        .r_en_o       (r_en_o),
        .r_data_i     (r_data_i),
        .wb_valid_o   (wb_valid_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .exc_valid_o  (exc_valid_o),
        .exc_store_o  (exc_store_o),
        .exc_code_o   (exc_code_o),
        .exc_addr_o   (exc_addr_o)
    );

    always #5 clk = ~clk;

    // Byte-lane data memory with one-cycle registered read.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_en_o[i]) mem[w_addr_o[MEM_AW-1:0]][8*i +: 8] <= w_data_o[8*i +: 8];
        end
        if (r_en_o) r_data_i <= mem[r_addr_o[MEM_AW-1:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    // -1 for a legal access, otherwise the expected exception code.
    function automatic int exp_exc(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (we ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 >= 3'd6)) return 1;
        if ((addr % nbytes(f3)) != 0) return 0;
        if (addr >= 32'(WORDS * 4)) return 2;
        return -1;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < nbytes(f3); i++) v[8*i +: 8] = ref_mem[addr + i];
        if (f3 == F3_LB) v = {{24{v[7]}}, v[7:0]};
        if (f3 == F3_LH) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full request from accept through exception or write-back.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        int          code;
        int          off;
        logic        legal;
        logic [3:0]  m;
        logic [31:0] lanes;
        logic [31:0] exp_wd;
        code  = exp_exc(we, f3, addr);
        legal = (code < 0);
        off   = int'(addr[1:0]);
        m     = 4'd0;
        lanes = 32'd0;
        exp_wd = 32'd0;
        if (legal && we) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + nbytes(f3)) begin
                    m[i] = 1'b1;
                    lanes[8*i +: 8] = 8'hFF;
                    exp_wd[8*i +: 8] = wdata[8*(i-off) +: 8];
                end
            end
        end
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_rd_i     = rd;
        #1;
        check("req_ready_idle", 32'(req_ready_o), 32'd1);
        check("r_en", 32'(r_en_o), 32'(legal && !we));
        check("w_en", 32'(w_en_o), 32'(m));
        if (legal && we) begin
            check("w_addr", w_addr_o, addr >> 2);
            check("w_data_lanes", w_data_o & lanes, exp_wd);
        end
        if (legal && !we) check("r_addr", r_addr_o, addr >> 2);
        step();
        req_valid_i = 1'b0;
        if (legal && we) begin
            for (int i = 0; i < nbytes(f3); i++) ref_mem[addr + i] = wdata[8*i +: 8];
        end
        check("exc_valid", 32'(exc_valid_o), 32'(!legal));
        check("wb_valid_early", 32'(wb_valid_o), 32'd0);
        if (!legal) begin
            check("exc_code", 32'(exc_code_o), 32'(code));
            check("exc_addr", exc_addr_o, addr);
            check("exc_store", 32'(exc_store_o), 32'(we));
        end
        if (legal && !we) begin
            check("req_ready_wait", 32'(req_ready_o), 32'd0);
            step();
            check("wb_valid", 32'(wb_valid_o), 32'd1);
            check("wb_data", wb_data_o, exp_load(f3, addr));
            check("wb_rd", 32'(wb_rd_o), 32'(rd));
            check("exc_quiet", 32'(exc_valid_o), 32'd0);
            check("req_ready_back", 32'(req_ready_o), 32'd1);
        end
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_exc_valid", 32'(exc_valid_o), 32'd0);
        check("rst_exc_store", 32'(exc_store_o), 32'd0);
        check("rst_wb_rd", 32'(wb_rd_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_exc_code", 32'(exc_code_o), 32'd0);
        check("rst_exc_addr", exc_addr_o, 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd1);
        rst_n = 1'b1;
        step();

        issue(1'b1, F3_SW, 32'h10, 32'hDEADBEEF, 5'd0);
        issue(1'b0, F3_LW, 32'h10, 32'd0, 5'd3);
        issue(1'b1, F3_SB, 32'h13, 32'h00000080, 5'd0);
        issue(1'b0, F3_LB, 32'h13, 32'd0, 5'd4);
        issue(1'b0, F3_LBU, 32'h13, 32'd0, 5'd5);
        issue(1'b1, F3_SH, 32'h22, 32'h00008001, 5'd0);
        issue(1'b0, F3_LH, 32'h22, 32'd0, 5'd6);
        issue(1'b0, F3_LHU, 32'h22, 32'd0, 5'd7);
        issue(1'b0, F3_LW, 32'h11, 32'd0, 5'd8);
        issue(1'b0, 3'd3, 32'h10, 32'd0, 5'd9);
        issue(1'b0, F3_LW, 32'h0001_0000, 32'd0, 5'd10);
        issue(1'b1, 3'd4, 32'h10, 32'h1234, 5'd0);
        issue(1'b1, F3_SH, 32'h0000_3FFF, 32'h1234, 5'd0);
        // Back-to-back stores, then a load of the same word in the next cycle.
        issue(1'b1, F3_SB, 32'h30, 32'h000000A5, 5'd0);
        issue(1'b1, F3_SB, 32'h31, 32'h0000005A, 5'd0);
        issue(1'b1, F3_SH, 32'h32, 32'h0000C3C3, 5'd0);
        issue(1'b0, F3_LW, 32'h30, 32'd0, 5'd11);
        issue(1'b1, F3_SW, 32'h3FFC, 32'h89ABCDEF, 5'd0);
        issue(1'b0, F3_LH, 32'h3FFE, 32'd0, 5'd12);

        // Flush in IDLE blocks acceptance of both a store and a faulting load.
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = F3_SW;
        req_addr_i = 32'h40; req_wdata_i = 32'hFFFFFFFF; flush_i = 1'b1;
        #1;
        check("flush_ready", 32'(req_ready_o), 32'd0);
        check("flush_w_en", 32'(w_en_o), 32'd0);
        req_we_i = 1'b0; req_addr_i = 32'h41;
        #1;
        check("flush_r_en", 32'(r_en_o), 32'd0);
        step();
        req_valid_i = 1'b0; flush_i = 1'b0;
        check("flush_no_exc", 32'(exc_valid_o), 32'd0);
        issue(1'b0, F3_LW, 32'h40, 32'd0, 5'd13);

        // Flush during LOAD_WAIT discards the result.
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = F3_LW;
        req_addr_i = 32'h10; req_rd_i = 5'd14;
        step();
        req_valid_i = 1'b0; flush_i = 1'b1;
        #1;
        check("lw_flush_ready", 32'(req_ready_o), 32'd0);
        step();
        flush_i = 1'b0;
        check("lw_flush_no_wb", 32'(wb_valid_o), 32'd0);
        step();
        check("lw_flush_no_wb2", 32'(wb_valid_o), 32'd0);

        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? 32'h0000_4000 + $urandom_range(0, 15)
                                                : 32'($urandom_range(0, 63));
            issue(we, f3, addr, $urandom, 5'($urandom_range(0, 31)));
        end

        // Reset while a load is pending: nothing is written back afterwards.
        req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = F3_LW;
        req_addr_i = 32'h10; req_rd_i = 5'd15;
        step();
        req_valid_i = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_no_wb", 32'(wb_valid_o), 32'd0);
        check("mid_rst_wb_data", wb_data_o, 32'd0);
        check("mid_rst_wb_rd", 32'(wb_rd_o), 32'd0);
        step();
        check("mid_rst_no_wb2", 32'(wb_valid_o), 32'd0);
        check("mid_rst_ready", 32'(req_ready_o), 32'd1);
        issue(1'b0, F3_LW, 32'h10, 32'd0, 5'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
